// File: rtl/approx_pkg.sv
// Shared widths for the 8-bit approximate adder and its error monitor,
// plus the monitor's state encoding.
package approx_pkg;

  localparam int ADD_W = 8;
  localparam int SUM_W = 9;

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } mon_state_t;

endpackage

// File: rtl/err_dist.sv
// Error distance between the exact and approximate 9-bit sums.
module err_dist
  import approx_pkg::*;
(
  input  logic [SUM_W-1:0] exact,
  input  logic [SUM_W-1:0] approx,
  output logic [SUM_W-1:0] ed
);

  logic [SUM_W:0] diff;

  // One extra bit keeps the sign, so the magnitude never wraps.
  assign diff = {1'b0, exact} - {1'b0, approx};
  assign ed   = diff[SUM_W] ? SUM_W'(-diff) : diff[SUM_W-1:0];

endmodule

// File: rtl/approx_err_monitor.sv
// Accumulates error statistics of the approximate adder over WINDOW samples
// and presents one report per window on a valid/ready handshake.
module approx_err_monitor
  import approx_pkg::*;
#(
  parameter int WINDOW = 256,
  parameter int CNT_W  = $clog2(WINDOW) + 1,
  parameter int EDS_W  = SUM_W + CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ADD_W-1:0] in_a,
  input  logic [ADD_W-1:0] in_b,
  input  logic [SUM_W-1:0] in_approx,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_err_cnt,
  output logic [EDS_W-1:0] rpt_ed_sum,
  output logic [SUM_W-1:0] rpt_ed_max,
  output logic [SUM_W-1:0] rpt_med
);

  localparam int               LOG_W   = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(WINDOW);

  mon_state_t       state;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] done_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [EDS_W-1:0] ed_sum;
  logic [SUM_W-1:0] ed_max;

  logic [ADD_W-1:0] s1_a;
  logic [ADD_W-1:0] s1_b;
  logic [SUM_W-1:0] s1_approx;
  logic             s1_v;

  logic             accept;
  logic [SUM_W-1:0] exact;
  logic [SUM_W-1:0] ed;
  logic [EDS_W-1:0] sum_nxt;
  logic [SUM_W-1:0] max_nxt;
  logic [CNT_W-1:0] err_nxt;

  assign in_ready = !rst && (state == ACCUM) && (acc_cnt < WIN_CNT);
  assign accept   = in_valid && in_ready;

  assign exact = SUM_W'(s1_a) + SUM_W'(s1_b);

  err_dist u_err_dist (
    .exact  (exact),
    .approx (s1_approx),
    .ed     (ed)
  );

  assign sum_nxt = ed_sum + EDS_W'(ed);
  assign max_nxt = (ed > ed_max) ? ed : ed_max;
  assign err_nxt = err_cnt + {{(CNT_W-1){1'b0}}, |ed};

  // Stage 1 captures accepted samples; stage 2 folds the registered sample
  // into the window statistics and latches the report on the final sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACCUM;
      acc_cnt     <= '0;
      done_cnt    <= '0;
      err_cnt     <= '0;
      ed_sum      <= '0;
      ed_max      <= '0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_approx   <= '0;
      s1_v        <= 1'b0;
      rpt_valid   <= 1'b0;
      rpt_err_cnt <= '0;
      rpt_ed_sum  <= '0;
      rpt_ed_max  <= '0;
      rpt_med     <= '0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_a      <= in_a;
        s1_b      <= in_b;
        s1_approx <= in_approx;
        acc_cnt   <= acc_cnt + CNT_W'(1);
      end

      case (state)
        ACCUM: begin
          if (s1_v) begin
            ed_sum   <= sum_nxt;
            ed_max   <= max_nxt;
            err_cnt  <= err_nxt;
            done_cnt <= done_cnt + CNT_W'(1);
            if (done_cnt == WIN_CNT - CNT_W'(1)) begin
              state       <= REPORT;
              rpt_valid   <= 1'b1;
              rpt_err_cnt <= err_nxt;
              rpt_ed_sum  <= sum_nxt;
              rpt_ed_max  <= max_nxt;
              rpt_med     <= SUM_W'(sum_nxt >> LOG_W);
            end
          end
        end
        REPORT: begin
          if (rpt_ready) begin
            state     <= ACCUM;
            rpt_valid <= 1'b0;
            acc_cnt   <= '0;
            done_cnt  <= '0;
            err_cnt   <= '0;
            ed_sum    <= '0;
            ed_max    <= '0;
          end
        end
      endcase
    end
  end

endmodule
